// File: rtl/retire_sq.sv
// retire_sq: retire stage with tag-based kill, redirect and store queue.
// Optional RETIRE_STATS_EN adds retired/killed instruction counters.
module retire_sq #(
    parameter int NUM_RES   = 2,
    parameter int TAG_W     = 4,
    parameter int SQ_DEPTH  = 4,
    parameter int WB_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_RES*32-1:0]        result,
    input  logic [$clog2(NUM_RES)-1:0]   wb_sel,
    input  logic                         jump,
    input  logic                         we,
    input  logic [TAG_W-1:0]             instruction_tag,
    input  logic [3:0]                   write_in,
    output logic                         reg_we,
    output logic [31:0]                  WrData,
    output logic [31:0]                  New_pc,
    output logic                         new_pc_valid,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [31:0]                  write_address,
    output logic [31:0]                  DATA_out,
    output logic [3:0]                   write,
    output logic [TAG_W-1:0]             curr_tag,
    output logic [$clog2(SQ_DEPTH):0]    sq_count,
    output logic [31:0]                  retired_cnt,
    output logic [31:0]                  killed_cnt
);

    localparam int SEL_W = $clog2(NUM_RES);
    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                          accept, killed, live, push, pop;
    logic [31:0]                   sel_data;

    logic [WB_STAGES-1:0]          wb_vld_q, wb_vld_d;
    logic [WB_STAGES-1:0][31:0]    wb_dat_q, wb_dat_d;
    logic [TAG_W-1:0]              tag_q, tag_d;
    logic [31:0]                   npc_q, npc_d;
    logic                          npv_q, npv_d;

    logic [31:0]                   sq_addr_q [SQ_DEPTH];
    logic [31:0]                   sq_addr_d [SQ_DEPTH];
    logic [31:0]                   sq_data_q [SQ_DEPTH];
    logic [31:0]                   sq_data_d [SQ_DEPTH];
    logic [3:0]                    sq_mask_q [SQ_DEPTH];
    logic [3:0]                    sq_mask_d [SQ_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    assign in_ready = (cnt_q != CNT_W'(SQ_DEPTH));
    assign accept   = in_valid && in_ready;
    assign killed   = (instruction_tag != tag_q);
    assign live     = accept && !killed;
    assign push     = live && (write_in != 4'h0);
    assign mem_valid = (cnt_q != '0);
    assign pop      = mem_valid && mem_ready;

    // Pick the channel routed to the register bank
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            if (wb_sel == SEL_W'(i)) sel_data = result[i*32 +: 32];
        end
    end

    // Write-back delay line, tag advance and redirect capture
    always_comb begin
        wb_vld_d    = '0;
        wb_dat_d    = '0;
        wb_vld_d[0] = live && we;
        wb_dat_d[0] = (live && we) ? sel_data : 32'h0;
        for (int i = 1; i < WB_STAGES; i++) begin
            wb_vld_d[i] = wb_vld_q[i-1];
            wb_dat_d[i] = wb_dat_q[i-1];
        end
        tag_d = tag_q;
        npc_d = npc_q;
        npv_d = 1'b0;
        if (live && jump) begin
            tag_d = tag_q + TAG_W'(1);
            npc_d = result[63:32];
            npv_d = 1'b1;
        end
    end

    // Store queue push/pop bookkeeping
    always_comb begin
        sq_addr_d = sq_addr_q;
        sq_data_d = sq_data_q;
        sq_mask_d = sq_mask_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (push) begin
            sq_addr_d[wr_ptr_q] = result[63:32];
            sq_data_d[wr_ptr_q] = result[31:0];
            sq_mask_d[wr_ptr_q] = write_in;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_vld_q <= '0;
            wb_dat_q <= '0;
            tag_q    <= '0;
            npc_q    <= '0;
            npv_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                sq_addr_q[i] <= '0;
                sq_data_q[i] <= '0;
                sq_mask_q[i] <= '0;
            end
        end else begin
            wb_vld_q  <= wb_vld_d;
            wb_dat_q  <= wb_dat_d;
            tag_q     <= tag_d;
            npc_q     <= npc_d;
            npv_q     <= npv_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            sq_addr_q <= sq_addr_d;
            sq_data_q <= sq_data_d;
            sq_mask_q <= sq_mask_d;
        end
    end

    assign reg_we        = wb_vld_q[WB_STAGES-1];
    assign WrData        = wb_dat_q[WB_STAGES-1];
    assign New_pc        = npc_q;
    assign new_pc_valid  = npv_q;
    assign curr_tag      = tag_q;
    assign sq_count      = cnt_q;
    assign write_address = mem_valid ? sq_addr_q[rd_ptr_q] : 32'h0;
    assign DATA_out      = mem_valid ? sq_data_q[rd_ptr_q] : 32'h0;
    assign write         = mem_valid ? sq_mask_q[rd_ptr_q] : 4'h0;

`ifdef RETIRE_STATS_EN
    logic [31:0] ret_q, ret_d, kill_q, kill_d;

    // Count consumed instructions by outcome
    always_comb begin
        ret_d  = ret_q;
        kill_d = kill_q;
        if (live)             ret_d  = ret_q + 32'd1;
        if (accept && killed) kill_d = kill_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_q  <= '0;
            kill_q <= '0;
        end else begin
            ret_q  <= ret_d;
            kill_q <= kill_d;
        end
    end

    assign retired_cnt = ret_q;
    assign killed_cnt  = kill_q;
`else
    assign retired_cnt = 32'h0;
    assign killed_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_retire_sq.sv
// tb_retire_sq: directed and random checks of retire_sq against a
// queue-based reference model.
module tb_retire_sq;

    localparam int NR = 2;
    localparam int TW = 4;
    localparam int SD = 4;
    localparam int WS = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   result;
    logic [0:0]    wb_sel;
    logic          jump;
    logic          we;
    logic [3:0]    instruction_tag;
    logic [3:0]    write_in;
    logic          reg_we;
    logic [31:0]   WrData;
    logic [31:0]   New_pc;
    logic          new_pc_valid;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   write_address;
    logic [31:0]   DATA_out;
    logic [3:0]    write;
    logic [3:0]    curr_tag;
    logic [2:0]    sq_count;
    logic [31:0]   retired_cnt;
    logic [31:0]   killed_cnt;

    retire_sq #(
        .NUM_RES(NR), .TAG_W(TW), .SQ_DEPTH(SD), .WB_STAGES(WS)
    ) dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .wb_sel(wb_sel),
        .jump(jump), .we(we),
        .instruction_tag(instruction_tag), .write_in(write_in),
        .reg_we(reg_we), .WrData(WrData),
        .New_pc(New_pc), .new_pc_valid(new_pc_valid),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .write_address(write_address), .DATA_out(DATA_out),
        .write(write), .curr_tag(curr_tag), .sq_count(sq_count),
        .retired_cnt(retired_cnt), .killed_cnt(killed_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0]   m_tag;
    logic [67:0]  m_sq[$];
    logic [31:0]  m_wb[int];
    logic         m_npv;
    logic [31:0]  m_npc;
    logic [31:0]  m_ret;
    logic [31:0]  m_kill;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] t, input bit w,
                         input bit s, input bit j, input logic [3:0] wi,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input bit mr);
        in_valid = v;
        instruction_tag = t;
        we = w;
        wb_sel = s;
        jump = j;
        write_in = wi;
        result = {r1, r0};
        mem_ready = mr;
    endtask

    task automatic check_all();
        logic [67:0] h;
        chk("reg_we", {31'h0, reg_we}, {31'h0, m_wb.exists(cyc)});
        if (m_wb.exists(cyc)) begin
            chk("WrData", WrData, m_wb[cyc]);
            m_wb.delete(cyc);
        end
        chk("new_pc_valid", {31'h0, new_pc_valid}, {31'h0, m_npv});
        chk("New_pc", New_pc, m_npc);
        chk("curr_tag", {28'h0, curr_tag}, {28'h0, m_tag});
        chk("sq_count", {29'h0, sq_count}, 32'(m_sq.size()));
        chk("mem_valid", {31'h0, mem_valid}, {31'h0, m_sq.size() != 0});
        chk("in_ready", {31'h0, in_ready}, {31'h0, m_sq.size() < SD});
        if (m_sq.size() != 0) begin
            h = m_sq[0];
            chk("write_address", write_address, h[67:36]);
            chk("DATA_out", DATA_out, h[35:4]);
            chk("write", {28'h0, write}, {28'h0, h[3:0]});
        end
`ifdef RETIRE_STATS_EN
        chk("retired_cnt", retired_cnt, m_ret);
        chk("killed_cnt", killed_cnt, m_kill);
`else
        chk("retired_cnt", retired_cnt, 32'h0);
        chk("killed_cnt", killed_cnt, 32'h0);
`endif
    endtask

    task automatic cycle();
        bit acc, live, popm;
        logic [31:0] r0, r1;
        acc  = in_valid && (m_sq.size() < SD);
        live = acc && (instruction_tag == m_tag);
        popm = (m_sq.size() != 0) && mem_ready;
        r0 = result[31:0];
        r1 = result[63:32];
        @(posedge clk);
        cyc++;
        if (popm) m_sq.delete(0);
        m_npv = 1'b0;
        if (acc) begin
            if (live) m_ret++;
            else m_kill++;
        end
        if (live) begin
            if (we) m_wb[cyc + WS - 1] = wb_sel ? r1 : r0;
            if (jump) begin
                m_tag = m_tag + 4'd1;
                m_npv = 1'b1;
                m_npc = r1;
            end
            if (write_in != 4'h0) m_sq.push_back({r1, r0, write_in});
        end
        #1;
        check_all();
    endtask

    task automatic idle(input bit mr, input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, mr);
            cycle();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_tag = '0;
        m_sq.delete();
        m_wb.delete();
        m_npv = 1'b0;
        m_npc = '0;
        m_ret = '0;
        m_kill = '0;
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_sq_count", {29'h0, sq_count}, 32'h0);
        chk("rst_curr_tag", {28'h0, curr_tag}, 32'h0);
        chk("rst_reg_we", {31'h0, reg_we}, 32'h0);
        chk("rst_WrData", WrData, 32'h0);
        chk("rst_npv", {31'h0, new_pc_valid}, 32'h0);
        chk("rst_New_pc", New_pc, 32'h0);
        chk("rst_write_address", write_address, 32'h0);
        chk("rst_DATA_out", DATA_out, 32'h0);
        chk("rst_write", {28'h0, write}, 32'h0);
        chk("rst_retired", retired_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset();

        // straight-line retire
        drive(1, 0, 1, 0, 0, 0, 32'h1234, 32'h0, 0);
        cycle();
        idle(0, 3);

        // taken jump then stale instruction
        drive(1, 0, 0, 0, 1, 0, 32'h0, 32'h400, 0);
        cycle();
        drive(1, 0, 1, 0, 0, 0, 32'hdead, 32'h0, 0);
        cycle();
        idle(0, 3);

        // tag wrap after 16 jumps
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, m_tag, 0, 0, 1, 0, 32'h0, 32'h1000 + 32'(i) * 4, 0);
            cycle();
        end
        chk("tag_wrapped", {28'h0, curr_tag}, 32'h0);
        drive(1, 0, 1, 1, 0, 0, 32'h0, 32'hbeef, 0);
        cycle();
        idle(0, 3);

        // fill the queue, refuse a fifth store, then drain
        for (int i = 0; i < 4; i++) begin
            drive(1, m_tag, 0, 0, 0, 4'hF, 32'hd0 + 32'(i),
                  32'h10 + 32'(i) * 4, 0);
            cycle();
        end
        drive(1, m_tag, 0, 0, 0, 4'hF, 32'hd9, 32'h20, 0);
        cycle();
        idle(0, 1);
        idle(1, 6);

        // push and pop in the same cycle
        for (int i = 0; i < 2; i++) begin
            drive(1, m_tag, 0, 0, 0, 4'h3, 32'he0 + 32'(i),
                  32'h40 + 32'(i) * 4, 0);
            cycle();
        end
        drive(1, m_tag, 0, 0, 0, 4'hC, 32'he2, 32'h48, 1);
        cycle();
        chk("pushpop_count", {29'h0, sq_count}, 32'h2);
        idle(1, 4);

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            drive(1, m_tag, 0, 0, 0, 4'h5, 32'hf0 + 32'(i),
                  32'h80 + 32'(i) * 4, 0);
            cycle();
        end
        do_reset();
        idle(1, 4);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] t;
            t = ($urandom_range(0, 3) == 0) ? 4'($urandom) : m_tag;
            drive($urandom_range(0, 3) != 0, t,
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                  $urandom, $urandom,
                  $urandom_range(0, 2) != 0);
            cycle();
        end
        idle(1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_sq.md
# retire_sq

Parametrised retire stage for the asynchronous RISC-V core that generalises result-channel count, tag width and write-back latency. It filters killed instructions by tag comparison and advances the speculation tag on taken jumps. Memory writes are buffered in a store queue drained to the data memory over a valid/ready handshake. It sits between the execute units and the register bank, PC-fetch and data-memory ports.

## Interface
- NUM_RES, 2, number of 32-bit result channels; channel 0 = data / write-back value, channel 1 = address / jump target; minimum 2
- TAG_W, 4, instruction/retire tag width
- SQ_DEPTH, 4, store-queue entries; power of two, at least 2
- WB_STAGES, 2, register write-back pipeline depth; at least 1
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  retiring instruction present
- in_ready  out  1  retire can accept this cycle
- result  in  NUM_RES x 32  result vector, one channel per unit
- wb_sel  in  clog2(NUM_RES)  channel driven to WrData
- jump  in  1  taken jump from branch unit
- we  in  1  register write request
- instruction_tag  in  TAG_W  tag of retiring instruction
- write_in  in  4  byte-lane store mask; nonzero = store
- reg_we  out  1  register-bank write enable
- WrData  out  32  register-bank write data
- New_pc  out  32  redirected PC
- new_pc_valid  out  1  one-cycle redirect pulse
- mem_valid  out  1  store-queue head valid
- mem_ready  in  1  data memory accepts head
- write_address  out  32  head store address
- DATA_out  out  32  head store data
- write  out  4  head byte mask
- curr_tag  out  TAG_W  current retire tag
- sq_count  out  clog2(SQ_DEPTH)+1  occupied entries

## Operation
- accept = in_valid && in_ready.
- killed = (instruction_tag != curr_tag), combinational.
- in_ready = 0 only when sq_count == SQ_DEPTH; otherwise 1, independent of instruction type.
- Accepted and not killed:
  - we=1 pushes result[wb_sel] into the write-back pipe.
  - jump=1 sets curr_tag <= curr_tag+1, modulo 2^TAG_W, wrapping silently.
  - jump=1 also registers result[1] to New_pc and pulses new_pc_valid.
  - write_in != 0 pushes {result[1], result[0], write_in} into the store queue.
- Accepted and killed: no register write, no tag change, no redirect, no push; the instruction is silently consumed.
- A single instruction may combine we, jump and store; each effect applies independently.
- Store queue:
  - FIFO with pointer wrap at SQ_DEPTH.
  - Pop on mem_valid && mem_ready.
  - Push and pop in the same cycle leave sq_count unchanged.
  - Enqueued stores are never killed.
- Once New_pc is latched, it holds until the next redirect.
- Reset mid-operation clears the queue, all pipes and curr_tag; in-flight stores are discarded.

## Timing
- Reset values:
  - reg_we, new_pc_valid, mem_valid and curr_tag reset to 0.
  - WrData, New_pc, write_address, DATA_out and write reset to 0.
  - sq_count resets to 0.
- reg_we/WrData: asserted WB_STAGES cycles after the accept edge, for exactly one cycle.
- New_pc/new_pc_valid: valid one cycle after the accept edge.
- curr_tag updates on the accept edge. The instruction accepted in the next cycle is compared against the new tag.
- Store: mem_valid is high no earlier than one cycle after the push edge. write_address, DATA_out and write remain stable while mem_valid && !mem_ready.
- in_ready derives from registered sq_count only, never from mem_ready. A pop therefore frees the full condition on the following cycle.

## Configuration
- RETIRE_STATS_EN:
  - Defined: adds two 32-bit wrapping output counters, retired_cnt (accepted and not killed) and killed_cnt (accepted and killed), both reset to 0 and updated on the accept edge.
  - Undefined: both ports exist and are tied to 0, with no counter logic.

## Test plan
- Straight-line retire: curr_tag=0; accept tag=0, we=1, wb_sel=0, result[0]=0x1234 -> reg_we=1, WrData=0x1234 exactly 2 cycles later (WB_STAGES=2).
- Taken jump then stale instruction:
  - Jump with tag 0 and result[1]=0x400 -> new_pc_valid pulse, New_pc=0x400, curr_tag=1.
  - Next instruction with tag 0 and we=1 -> no reg_we, curr_tag stays 1.
- Tag wrap: 16 consecutive valid jumps with TAG_W=4 -> curr_tag returns to 0; the 17th instruction with tag 0 retires normally.
- Store queue full:
  - mem_ready=0; push 4 stores (addr 0x10..0x1C, mask 0xF) -> sq_count=4, in_ready=0.
  - Raise mem_ready -> entries drain in order, one per cycle, and in_ready=1 the cycle after the first pop.
- Simultaneous push/pop: with sq_count=2 and mem_ready=1, accept a store -> sq_count stays 2 and head order is preserved.
- Reset mid-drain: assert reset with 3 queued stores -> mem_valid=0, sq_count=0, curr_tag=0 immediately; no store emitted after release.
